seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the 8-bit combinational ALU used by the datapath.
- Keeps the eight legacy ops at WIDTH bits.
- Adds an iterative shift-add multiply and variable-count shifts.
- All results and flags are registered behind a start/busy/done handshake.
- Sits between the register-file read ports and the writeback mux; the controller stalls on busy_o.

Parameters:
WIDTH, 8, datapath width in bits (>=4).
SHW, $clog2(WIDTH), derived: shift-count field width; not overridable.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  launch operation; sampled only when busy_o=0
op_i  in  4  opcode (alu_pkg::alu_op_e)
ina_i  in  WIDTH  operand A
inb_i  in  WIDTH  operand B / shift count in inb_i[SHW-1:0]
sc_i  in  1  shift/carry in
busy_o  out  1  operation in flight
done_o  out  1  one-cycle pulse: results valid
rslt_o  out  WIDTH  result (low half for MUL)
rslt_hi_o  out  WIDTH  MUL high half; 0 for other ops
sc_o  out  1  carry/shift-out
pari_o  out  1  ^rslt_o
zero_o  out  1  ~|rslt_o
illegal_o  out  1  op was illegal

Behaviour:
- Reset: every output is 0; FSM goes to IDLE. Asynchronous assertion, synchronous-safe deassertion. Reset mid-operation discards the partial result; no done_o.
- FSM: IDLE -> EXEC on accepted start; EXEC -> IDLE when count hits 0. Operands, op and sc_i are latched at the accepting edge k.
- Latency L: done_o is high in the cycle after edge k+L-1, i.e. L cycles after start.
  - busy_o is high for the L-1 cycles before done_o, low during done_o.
  - L=1 ops never raise busy_o.
- Back-to-back: start_i in the done_o cycle is accepted.
- start_i while busy_o=1 is ignored; it is not queued.
- Outputs hold their values until the next done_o.
- Ops, with L in parentheses; arithmetic is (WIDTH+1)-bit, sc_o = bit WIDTH:
  - 0 ADD (1): {sc_o,rslt} = A+B+sc_i.
  - 1 SHL1 (1): {sc_o,rslt} = {A,sc_i}.
  - 2 SHR1 (1): {rslt,sc_o} = {sc_i,A}.
  - 3 XOR (1); 4 AND (1): sc_o=0.
  - 5 ROL1 (1): rslt = {A[W-2:0],A[W-1]}, sc_o=0.
  - 6 SUB (1): {sc_o,rslt} = A-B+sc_i.
  - 7 PASSA (1): sc_o=0.
  - 8 MUL (WIDTH): unsigned, one partial product per cycle. {rslt_hi,rslt} = A*B; sc_o = |rslt_hi.
  - 9 SHLN / 10 SHRN (max(N,1), N = inb_i[SHW-1:0]): logical shift, one bit per cycle, zero fill. sc_o = last bit shifted out. N=0 gives rslt=A, sc_o=0, L=1.
  - 11-15: illegal (1). rslt=0, sc_o=0, illegal_o=1.
- illegal_o updates at every done_o; it is 0 for legal ops.
- Flags pari_o and zero_o are computed from the final registered rslt_o only, never from a stale value. MUL flags ignore rslt_hi_o.

Optional Feature:
ALU_MUL_EN
- Defined: op 8 is the iterative multiplier described above.
- Undefined: no multiplier logic is built.
  - op 8 is treated as illegal (L=1, illegal_o=1).
  - rslt_hi_o is tied to 0.

Decomposition:
- alu_pkg:
  - alu_op_e enum (4-bit, values above).
  - localparam OP_ILLEGAL_MIN=11.
  - state_e {IDLE,EXEC}.
  - function op_latency(op, cnt, width).
- Sub-module alu_shift_add_mul, guarded by ALU_MUL_EN.
  - Ports: clk, rst_n, load, A, B, step.
  - Outputs: {hi,lo} and its own step counter.
- The shift iterator stays in seq_alu.

Test Plan:
- ADD ina=0xFF, inb=0x01, sc_i=0 -> done_o one cycle after start; rslt 0x00, sc_o 1, zero_o 1, pari_o 0, busy_o never high.
- MUL 0xFF*0xFF (ALU_MUL_EN) -> busy_o high 7 cycles, done_o on 8th; hi 0xFE, lo 0x01, sc_o 1, pari_o 1. Then MUL 0x0F*0x11 -> 0x00FF, sc_o 0.
- SHRN ina=0x81, inb=3 -> done_o after 3 cycles; rslt 0x10, sc_o 0. SHLN ina=0x81, inb=0 -> L=1, rslt 0x81, sc_o 0.
- Assert start_i with ADD during a MUL -> ignored, MUL result unchanged. Start SUB 0x05-0x07+0 in the done cycle -> accepted; rslt 0xFE, sc_o 1, done_o one cycle later.
- rst_n low at cycle 4 of a MUL -> all outputs 0 immediately, no done_o. A new start after release operates normally.
- op 0xB -> illegal_o 1, rslt 0, zero_o 1. Without ALU_MUL_EN, op 8 -> illegal_o 1, rslt_hi_o 0. Rerun ADD with WIDTH=16: 0xFFFF+1 -> 0x0000, sc_o 1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the sequential ALU.
// ALU_MUL_EN selects whether opcode 8 is a legal multi-cycle multiply.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SHL1  = 4'd1,
    OP_SHR1  = 4'd2,
    OP_XOR   = 4'd3,
    OP_AND   = 4'd4,
    OP_ROL1  = 4'd5,
    OP_SUB   = 4'd6,
    OP_PASSA = 4'd7,
    OP_MUL   = 4'd8,
    OP_SHLN  = 4'd9,
    OP_SHRN  = 4'd10
  } alu_op_e;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  function automatic logic op_is_illegal(alu_op_e op);
    logic ill;
    ill = (4'(op) >= OP_ILLEGAL_MIN);
`ifndef ALU_MUL_EN
    if (op == OP_MUL) ill = 1'b1;
`endif
    return ill;
  endfunction

  // Cycles from accepted start to done; a zero-count shift still takes one cycle.
  function automatic int op_latency(alu_op_e op, int cnt, int width);
    int lat;
    lat = 1;
    if (!op_is_illegal(op)) begin
      case (op)
        OP_MUL:          lat = width;
        OP_SHLN, OP_SHRN: lat = (cnt < 1) ? 1 : cnt;
        default:         lat = 1;
      endcase
    end
    return lat;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Start/busy/done handshake bundle between the controller and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic             start_i;
  alu_op_e          op_i;
  logic [WIDTH-1:0] ina_i;
  logic [WIDTH-1:0] inb_i;
  logic             sc_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] rslt_o;
  logic [WIDTH-1:0] rslt_hi_o;
  logic             sc_o;
  logic             pari_o;
  logic             zero_o;
  logic             illegal_o;

  modport master (
    output start_i, op_i, ina_i, inb_i, sc_i,
    input  busy_o, done_o, rslt_o, rslt_hi_o, sc_o, pari_o, zero_o, illegal_o
  );

  modport slave (
    input  start_i, op_i, ina_i, inb_i, sc_i,
    output busy_o, done_o, rslt_o, rslt_hi_o, sc_o, pari_o, zero_o, illegal_o
  );

endinterface

// File: rtl/seq_alu_shift_add_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per step; only built with ALU_MUL_EN.
// hi/lo present the product as it will be after the current load/step, so the last step can be captured directly.
module alu_shift_add_mul #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [CNTW-1:0]  cnt
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mcand_q;
  logic [CNTW-1:0]  cnt_q;

  logic [WIDTH-1:0] cur_hi;
  logic [WIDTH-1:0] cur_lo;
  logic [WIDTH-1:0] cur_mcand;
  logic [WIDTH:0]   sum;

  // A load performs the first partial product straight from the operands.
  always_comb begin
    cur_hi    = load ? '0 : hi_q;
    cur_lo    = load ? b  : lo_q;
    cur_mcand = load ? a  : mcand_q;
    sum       = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_mcand} : '0);
    hi        = sum[WIDTH:1];
    lo        = {sum[0], cur_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      hi_q    <= hi;
      lo_q    <= lo;
      mcand_q <= a;
      cnt_q   <= CNTW'(WIDTH - 1);
    end else if (step) begin
      hi_q <= hi;
      lo_q <= lo;
      if (cnt_q != '0) cnt_q <= cnt_q - CNTW'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle WIDTH-bit ALU with registered results behind a start/busy/done handshake.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 8; otherwise that opcode is illegal.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH + 1);

  state_e           state;
  alu_op_e          op_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] rslt_q;
  logic             sc_q;
  logic             pari_q;
  logic             zero_q;
  logic             illegal_q;

  logic             accept;
  int               lat;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   fast_sum;
  logic [WIDTH-1:0] fast_rslt;
  logic             fast_sc;
  logic             fast_illegal;
  logic [WIDTH-1:0] step_src;
  logic [WIDTH-1:0] step_nxt;
  logic             step_out;
  alu_op_e          step_op;
  logic [WIDTH-1:0] fin_rslt;
  logic             fin_sc;
  logic             last;

  assign accept = bus.start_i && (state == IDLE);
  assign shamt  = bus.inb_i[SHW-1:0];
  assign lat    = op_latency(bus.op_i, int'(shamt), WIDTH);

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [CNTW-1:0]  mul_cnt;
  logic [WIDTH-1:0] rslt_hi_q;
  logic [WIDTH-1:0] fin_hi;

  alu_shift_add_mul #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept && (bus.op_i == OP_MUL)),
    .a     (bus.ina_i),
    .b     (bus.inb_i),
    .step  ((state == EXEC) && (op_q == OP_MUL)),
    .hi    (mul_hi),
    .lo    (mul_lo),
    .cnt   (mul_cnt)
  );

  assign bus.rslt_hi_o = rslt_hi_q;
  assign last = (op_q == OP_MUL) ? (mul_cnt == CNTW'(1)) : (cnt_q == CNTW'(1));
`else
  assign bus.rslt_hi_o = '0;
  assign last = (cnt_q == CNTW'(1));
`endif

  // One-bit shift step, fed from the operand at accept time and from sh_q while iterating.
  always_comb begin
    step_src = (state == IDLE) ? bus.ina_i : sh_q;
    step_op  = (state == IDLE) ? bus.op_i  : op_q;
    if (step_op == OP_SHRN) begin
      step_nxt = {1'b0, step_src[WIDTH-1:1]};
      step_out = step_src[0];
    end else begin
      step_nxt = {step_src[WIDTH-2:0], 1'b0};
      step_out = step_src[WIDTH-1];
    end
  end

  always_comb begin
    fast_sum     = '0;
    fast_rslt    = '0;
    fast_sc      = 1'b0;
    fast_illegal = op_is_illegal(bus.op_i);
    case (bus.op_i)
      OP_ADD: begin
        fast_sum = {1'b0, bus.ina_i} + {1'b0, bus.inb_i} + {{WIDTH{1'b0}}, bus.sc_i};
        {fast_sc, fast_rslt} = fast_sum;
      end
      OP_SHL1:  {fast_sc, fast_rslt} = {bus.ina_i, bus.sc_i};
      OP_SHR1:  {fast_rslt, fast_sc} = {bus.sc_i, bus.ina_i};
      OP_XOR:   fast_rslt = bus.ina_i ^ bus.inb_i;
      OP_AND:   fast_rslt = bus.ina_i & bus.inb_i;
      OP_ROL1:  fast_rslt = {bus.ina_i[WIDTH-2:0], bus.ina_i[WIDTH-1]};
      OP_SUB: begin
        fast_sum = {1'b0, bus.ina_i} - {1'b0, bus.inb_i} + {{WIDTH{1'b0}}, bus.sc_i};
        {fast_sc, fast_rslt} = fast_sum;
      end
      OP_PASSA: fast_rslt = bus.ina_i;
      OP_SHLN, OP_SHRN: begin
        if (shamt == '0) begin
          fast_rslt = bus.ina_i;
        end else begin
          fast_rslt = step_nxt;
          fast_sc   = step_out;
        end
      end
      default: begin
        fast_rslt = '0;
        fast_sc   = 1'b0;
      end
    endcase
  end

  always_comb begin
    fin_rslt = step_nxt;
    fin_sc   = step_out;
`ifdef ALU_MUL_EN
    fin_hi   = '0;
    if (op_q == OP_MUL) begin
      fin_rslt = mul_lo;
      fin_hi   = mul_hi;
      fin_sc   = |mul_hi;
    end
`endif
  end

  // Single-cycle ops finish on the accepting edge; the rest iterate in EXEC until the count runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      cnt_q     <= '0;
      sh_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rslt_q    <= '0;
      sc_q      <= 1'b0;
      pari_q    <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      rslt_hi_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= bus.op_i;
            if (lat > 1) begin
              state  <= EXEC;
              busy_q <= 1'b1;
              cnt_q  <= CNTW'(lat - 1);
              sh_q   <= step_nxt;
            end else begin
              done_q    <= 1'b1;
              rslt_q    <= fast_rslt;
              sc_q      <= fast_sc;
              pari_q    <= ^fast_rslt;
              zero_q    <= ~|fast_rslt;
              illegal_q <= fast_illegal;
`ifdef ALU_MUL_EN
              rslt_hi_q <= '0;
`endif
            end
          end
        end
        EXEC: begin
          if (last) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            cnt_q     <= '0;
            rslt_q    <= fin_rslt;
            sc_q      <= fin_sc;
            pari_q    <= ^fin_rslt;
            zero_q    <= ~|fin_rslt;
            illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
            rslt_hi_q <= fin_hi;
`endif
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
            sh_q  <= step_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.rslt_o    = rslt_q;
  assign bus.sc_o      = sc_q;
  assign bus.pari_o    = pari_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed scenarios plus random ops against an arithmetic reference model.
// Works with or without ALU_MUL_EN defined.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   assert_cnt;
  int   fail_cnt;

`ifdef ALU_MUL_EN
  localparam int LONG_OP = 8;
  localparam int LONG_B  = 8'hFF;
`else
  localparam int LONG_OP = 9;
  localparam int LONG_B  = 7;
`endif

  seq_alu_if #(.WIDTH(8))  bus ();
  seq_alu_if #(.WIDTH(16)) bus16 ();

  seq_alu #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  // Behavioural reference for WIDTH=8, built straight from the op definitions.
  function automatic void ref_model(input int op, input int a, input int b, input int sc,
                                    output int rslt, output int hi, output int sco,
                                    output int ill, output int lat);
    int t;
    int n;
    n = b & 7;
    rslt = 0; hi = 0; sco = 0; ill = 0; lat = 1;
    case (op)
      0:  begin t = (a + b + sc + 512) % 512; rslt = t & 255; sco = (t >> 8) & 1; end
      1:  begin t = a * 2 + sc; rslt = t & 255; sco = (t >> 8) & 1; end
      2:  begin rslt = (sc << 7) | (a >> 1); sco = a & 1; end
      3:  rslt = a ^ b;
      4:  rslt = a & b;
      5:  rslt = ((a << 1) | (a >> 7)) & 255;
      6:  begin t = (a - b + sc + 512) % 512; rslt = t & 255; sco = (t >> 8) & 1; end
      7:  rslt = a;
      8: begin
`ifdef ALU_MUL_EN
        t = a * b; rslt = t & 255; hi = t >> 8; sco = (hi != 0) ? 1 : 0; lat = 8;
`else
        ill = 1;
`endif
      end
      9: begin
        if (n == 0) rslt = a;
        else begin rslt = (a << n) & 255; sco = (a >> (8 - n)) & 1; lat = n; end
      end
      10: begin
        if (n == 0) rslt = a;
        else begin rslt = a >> n; sco = (a >> (n - 1)) & 1; lat = n; end
      end
      default: ill = 1;
    endcase
  endfunction

  // Drives one start pulse and waits for done_o; leaves the bench on the done cycle.
  task automatic do_op(input int op, input int a, input int b, input int sc,
                       output int lat_obs, output int busy_cnt, output logic timeout);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = alu_op_e'(4'(op));
    bus.ina_i   = 8'(a);
    bus.inb_i   = 8'(b);
    bus.sc_i    = 1'(sc);
    @(negedge clk);
    bus.start_i = 1'b0;
    lat_obs  = 1;
    busy_cnt = 0;
    while (!bus.done_o && lat_obs < 40) begin
      if (bus.busy_o) busy_cnt++;
      @(negedge clk);
      lat_obs++;
    end
    timeout = !bus.done_o;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    assert_cnt++;
    if ({bus.busy_o, bus.done_o, bus.rslt_o, bus.rslt_hi_o, bus.sc_o, bus.pari_o, bus.zero_o, bus.illegal_o} !== '0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b rslt=%h hi=%h sc=%b p=%b z=%b ill=%b expected all 0",
               bus.busy_o, bus.done_o, bus.rslt_o, bus.rslt_hi_o, bus.sc_o, bus.pari_o, bus.zero_o, bus.illegal_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    assert_cnt++;
    if ({bus.busy_o, bus.done_o, bus.rslt_o} !== '0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_release: got busy=%b done=%b rslt=%h expected 0", bus.busy_o, bus.done_o, bus.rslt_o);
    end
  endtask

  task automatic test_add;
    int l, bc; logic to;
    do_op(0, 8'hFF, 8'h01, 0, l, bc, to);
    assert_cnt++;
    if (to || l != 1 || bc != 0) begin
      fail_cnt++;
      $display("[TB] FAIL add_latency: got lat=%0d busy=%0d timeout=%b expected lat=1 busy=0", l, bc, to);
    end
    assert_cnt++;
    if ({bus.rslt_o, bus.sc_o, bus.zero_o, bus.pari_o, bus.illegal_o} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      fail_cnt++;
      $display("[TB] FAIL add_result: got rslt=%h sc=%b z=%b p=%b ill=%b expected 00 1 1 0 0",
               bus.rslt_o, bus.sc_o, bus.zero_o, bus.pari_o, bus.illegal_o);
    end
  endtask

  task automatic test_mul;
    int l, bc; logic to;
`ifdef ALU_MUL_EN
    do_op(8, 8'hFF, 8'hFF, 0, l, bc, to);
    assert_cnt++;
    if (to || l != 8 || bc != 7) begin
      fail_cnt++;
      $display("[TB] FAIL mul_latency: got lat=%0d busy=%0d timeout=%b expected lat=8 busy=7", l, bc, to);
    end
    assert_cnt++;
    if ({bus.rslt_hi_o, bus.rslt_o, bus.sc_o, bus.pari_o, bus.busy_o} !== {16'hFE01, 1'b1, 1'b1, 1'b0}) begin
      fail_cnt++;
      $display("[TB] FAIL mul_ff_ff: got hi=%h lo=%h sc=%b p=%b busy=%b expected fe 01 1 1 0",
               bus.rslt_hi_o, bus.rslt_o, bus.sc_o, bus.pari_o, bus.busy_o);
    end
    do_op(8, 8'h0F, 8'h11, 0, l, bc, to);
    assert_cnt++;
    if (to || {bus.rslt_hi_o, bus.rslt_o, bus.sc_o} !== {16'h00FF, 1'b0}) begin
      fail_cnt++;
      $display("[TB] FAIL mul_0f_11: got hi=%h lo=%h sc=%b timeout=%b expected 00 ff 0", bus.rslt_hi_o, bus.rslt_o, bus.sc_o, to);
    end
`else
    do_op(8, 8'h12, 8'h34, 0, l, bc, to);
    assert_cnt++;
    if (to || l != 1 || {bus.illegal_o, bus.rslt_hi_o, bus.rslt_o, bus.zero_o} !== {1'b1, 16'h0000, 1'b1}) begin
      fail_cnt++;
      $display("[TB] FAIL mul_disabled: got lat=%0d ill=%b hi=%h lo=%h z=%b expected 1 1 00 00 1",
               l, bus.illegal_o, bus.rslt_hi_o, bus.rslt_o, bus.zero_o);
    end
`endif
  endtask

  task automatic test_shifts;
    int l, bc; logic to;
    do_op(10, 8'h81, 3, 0, l, bc, to);
    assert_cnt++;
    if (to || l != 3 || bc != 2 || {bus.rslt_o, bus.sc_o} !== {8'h10, 1'b0}) begin
      fail_cnt++;
      $display("[TB] FAIL shrn_3: got lat=%0d busy=%0d rslt=%h sc=%b expected 3 2 10 0", l, bc, bus.rslt_o, bus.sc_o);
    end
    do_op(9, 8'h81, 0, 1, l, bc, to);
    assert_cnt++;
    if (to || l != 1 || bc != 0 || {bus.rslt_o, bus.sc_o} !== {8'h81, 1'b0}) begin
      fail_cnt++;
      $display("[TB] FAIL shln_0: got lat=%0d busy=%0d rslt=%h sc=%b expected 1 0 81 0", l, bc, bus.rslt_o, bus.sc_o);
    end
  endtask

  task automatic test_back_to_back;
    int er, eh, es, ei, el, cyc;
    ref_model(LONG_OP, 8'hFF, LONG_B, 0, er, eh, es, ei, el);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = alu_op_e'(4'(LONG_OP));
    bus.ina_i   = 8'hFF;
    bus.inb_i   = 8'(LONG_B);
    bus.sc_i    = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0;
    cyc = 1;
    while (!bus.done_o && cyc < 40) begin
      if (cyc == 2) begin
        bus.start_i = 1'b1;
        bus.op_i    = OP_ADD;
        bus.ina_i   = 8'h01;
        bus.inb_i   = 8'h02;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    assert_cnt++;
    if (!bus.done_o || cyc != el || bus.rslt_o !== 8'(er) || bus.sc_o !== 1'(es) || bus.busy_o !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL ignore_start: got lat=%0d rslt=%h sc=%b busy=%b expected lat=%0d rslt=%h sc=%0d busy=0",
               cyc, bus.rslt_o, bus.sc_o, bus.busy_o, el, 8'(er), es);
    end
    bus.start_i = 1'b1;
    bus.op_i    = OP_SUB;
    bus.ina_i   = 8'h05;
    bus.inb_i   = 8'h07;
    bus.sc_i    = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0;
    assert_cnt++;
    if ({bus.done_o, bus.rslt_o, bus.sc_o} !== {1'b1, 8'hFE, 1'b1}) begin
      fail_cnt++;
      $display("[TB] FAIL back_to_back_sub: got done=%b rslt=%h sc=%b expected 1 fe 1", bus.done_o, bus.rslt_o, bus.sc_o);
    end
    @(negedge clk);
    assert_cnt++;
    if (bus.done_o !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL no_queued_start: got done=%b expected 0", bus.done_o);
    end
  endtask

  task automatic test_reset_mid_op;
    int seen, l, bc; logic to;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = alu_op_e'(4'(LONG_OP));
    bus.ina_i   = 8'hA5;
    bus.inb_i   = 8'(LONG_B);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    assert_cnt++;
    if ({bus.busy_o, bus.done_o, bus.rslt_o, bus.rslt_hi_o, bus.sc_o, bus.pari_o, bus.zero_o, bus.illegal_o} !== '0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_mid_op: got busy=%b done=%b rslt=%h hi=%h sc=%b expected all 0",
               bus.busy_o, bus.done_o, bus.rslt_o, bus.rslt_hi_o, bus.sc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done_o) seen++;
    end
    assert_cnt++;
    if (seen != 0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_no_done: got %0d done pulses expected 0", seen);
    end
    do_op(0, 8'h03, 8'h04, 0, l, bc, to);
    assert_cnt++;
    if (to || bus.rslt_o !== 8'h07 || bus.pari_o !== 1'b1) begin
      fail_cnt++;
      $display("[TB] FAIL after_reset_add: got rslt=%h p=%b expected 07 1", bus.rslt_o, bus.pari_o);
    end
  endtask

  task automatic test_illegal;
    int l, bc; logic to;
    do_op(11, 8'h5A, 8'h3C, 1, l, bc, to);
    assert_cnt++;
    if (to || l != 1 || {bus.illegal_o, bus.rslt_o, bus.zero_o, bus.sc_o} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      fail_cnt++;
      $display("[TB] FAIL illegal_op: got lat=%0d ill=%b rslt=%h z=%b sc=%b expected 1 1 00 1 0",
               l, bus.illegal_o, bus.rslt_o, bus.zero_o, bus.sc_o);
    end
  endtask

  task automatic test_random_ops;
    int op, a, b, sc, er, eh, es, ei, el, l, bc;
    logic to;
    logic [7:0] r8;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      sc = $urandom_range(0, 1);
      ref_model(op, a, b, sc, er, eh, es, ei, el);
      r8 = 8'(er);
      do_op(op, a, b, sc, l, bc, to);
      assert_cnt++;
      if (to || l != el || bc != el - 1) begin
        fail_cnt++;
        $display("[TB] FAIL rand_timing op=%0d: got lat=%0d busy=%0d expected lat=%0d busy=%0d", op, l, bc, el, el - 1);
      end
      assert_cnt++;
      if ({bus.rslt_o, bus.rslt_hi_o, bus.sc_o, bus.illegal_o} !== {r8, 8'(eh), 1'(es), 1'(ei)}) begin
        fail_cnt++;
        $display("[TB] FAIL rand_result op=%0d a=%h b=%h sc=%0d: got rslt=%h hi=%h sc=%b ill=%b expected %h %h %0d %0d",
                 op, a, b, sc, bus.rslt_o, bus.rslt_hi_o, bus.sc_o, bus.illegal_o, r8, 8'(eh), es, ei);
      end
      assert_cnt++;
      if (bus.pari_o !== ($countones(r8) % 2 == 1) || bus.zero_o !== (r8 == 8'h00)) begin
        fail_cnt++;
        $display("[TB] FAIL rand_flags op=%0d: got p=%b z=%b for rslt=%h", op, bus.pari_o, bus.zero_o, r8);
      end
    end
  endtask

  task automatic test_width16;
    int a, b, s;
    @(negedge clk);
    bus16.start_i = 1'b1;
    bus16.op_i    = OP_ADD;
    bus16.ina_i   = 16'hFFFF;
    bus16.inb_i   = 16'h0001;
    bus16.sc_i    = 1'b0;
    @(negedge clk);
    bus16.start_i = 1'b0;
    assert_cnt++;
    if ({bus16.done_o, bus16.rslt_o, bus16.sc_o, bus16.zero_o} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
      fail_cnt++;
      $display("[TB] FAIL w16_add_wrap: got done=%b rslt=%h sc=%b z=%b expected 1 0000 1 1",
               bus16.done_o, bus16.rslt_o, bus16.sc_o, bus16.zero_o);
    end
    a = $urandom_range(0, 65535);
    b = $urandom_range(0, 65535);
    s = a + b + 1;
    bus16.start_i = 1'b1;
    bus16.ina_i   = 16'(a);
    bus16.inb_i   = 16'(b);
    bus16.sc_i    = 1'b1;
    @(negedge clk);
    bus16.start_i = 1'b0;
    assert_cnt++;
    if ({bus16.done_o, bus16.sc_o, bus16.rslt_o} !== {1'b1, 17'(s)}) begin
      fail_cnt++;
      $display("[TB] FAIL w16_add_rand: got done=%b sc=%b rslt=%h expected 1 %h", bus16.done_o, bus16.sc_o, bus16.rslt_o, 17'(s));
    end
  endtask

  initial begin
    assert_cnt    = 0;
    fail_cnt      = 0;
    bus.start_i   = 1'b0;
    bus.op_i      = OP_ADD;
    bus.ina_i     = '0;
    bus.inb_i     = '0;
    bus.sc_i      = 1'b0;
    bus16.start_i = 1'b0;
    bus16.op_i    = OP_ADD;
    bus16.ina_i   = '0;
    bus16.inb_i   = '0;
    bus16.sc_i    = 1'b0;
    $display("[TB] starting seq_alu bench");
    test_reset();
    test_add();
    test_mul();
    test_shifts();
    test_back_to_back();
    test_reset_mid_op();
    test_illegal();
    test_random_ops();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
